// File: rtl/aes_round_sched.sv
// Iterative AES round scheduler: whitens a block with key0, then steps it through NR rounds of an external datapath.
// Define AES_SCHED_OVERLAP_EN to accept the next block in the same cycle the finished one is handed off.
module aes_round_sched #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_select,
   input  logic [127:0] key0,
   output logic [127:0] rnd_state,
   output logic [3:0]   rnd_num,
   output logic         rnd_final,
   output logic         rnd_select,
   input  logic [127:0] rnd_result,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] LastRound = 4'(NR);

   state_t       state_q, state_d;
   logic [127:0] rndState_q, rndState_d;
   logic [3:0]   rndNum_q, rndNum_d;
   logic         rndSelect_q, rndSelect_d;
   logic [127:0] outData_q, outData_d;
   logic         outValid_q, outValid_d;
   logic         accept;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (rndNum_q == LastRound) state_d = DONE;
         DONE:    if (out_ready) state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      rnd_final = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: in_ready = 1'b1;
         RUN:  rnd_final = (rndNum_q == LastRound);
         DONE: begin
`ifdef AES_SCHED_OVERLAP_EN
            in_ready = out_ready;
`else
            in_ready = 1'b0;
`endif
         end
         default: in_ready = 1'b0;
      endcase
   end

   // A new acceptance overrides everything else, which also covers the overlapped DONE->RUN handoff.
   always_comb begin
      rndState_d  = rndState_q;
      rndNum_d    = rndNum_q;
      rndSelect_d = rndSelect_q;
      outData_d   = outData_q;
      outValid_d  = outValid_q;
      if (state_q == DONE && out_ready) begin
         outValid_d = 1'b0;
      end
      if (state_q == RUN) begin
         if (rndNum_q == LastRound) begin
            outData_d  = rnd_result;
            outValid_d = 1'b1;
         end else begin
            rndState_d = rnd_result;
            rndNum_d   = rndNum_q + 4'd1;
         end
      end
      if (accept) begin
         rndState_d  = in_data ^ key0;
         rndNum_d    = 4'd1;
         rndSelect_d = in_select;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rndState_q  <= '0;
         rndNum_q    <= '0;
         rndSelect_q <= 1'b0;
         outData_q   <= '0;
         outValid_q  <= 1'b0;
      end else begin
         rndState_q  <= rndState_d;
         rndNum_q    <= rndNum_d;
         rndSelect_q <= rndSelect_d;
         outData_q   <= outData_d;
         outValid_q  <= outValid_d;
      end
   end

   assign rnd_state  = rndState_q;
   assign rnd_num    = rndNum_q;
   assign rnd_select = rndSelect_q;
   assign out_data   = outData_q;
   assign out_valid  = outValid_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched; the external round is modelled as state ^ round number.
// Honours AES_SCHED_OVERLAP_EN when deriving the expected back-to-back acceptance spacing.
module tb_aes_round_sched;

   localparam int NR = 10;
`ifdef AES_SCHED_OVERLAP_EN
   localparam int ExpGap = 11;
`else
   localparam int ExpGap = 12;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_select;
   logic [127:0] key0;
   logic [127:0] rnd_state;
   logic [3:0]   rnd_num;
   logic         rnd_final;
   logic         rnd_select;
   logic [127:0] rnd_result;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int compareCount = 0;
   int failCount = 0;

   aes_round_sched #(.NR(NR)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_select  (in_select),
      .key0       (key0),
      .rnd_state  (rnd_state),
      .rnd_num    (rnd_num),
      .rnd_final  (rnd_final),
      .rnd_select (rnd_select),
      .rnd_result (rnd_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign rnd_result = rnd_state ^ {124'h0, rnd_num};

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [127:0] data, input logic sel,
                                input logic [127:0] key, input logic ready);
      in_valid  = valid;
      in_data   = data;
      in_select = sel;
      key0      = key;
      out_ready = ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int validSeen;
      int accepts;
      int firstEdge;
      int secondEdge;
      logic selBit;

      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      tick();
      tick();
      checkOutput("rst_outValid", 128'(out_valid), 128'(0));
      checkOutput("rst_busy", 128'(busy), 128'(0));
      checkOutput("rst_rndNum", 128'(rnd_num), 128'(0));
      checkOutput("rst_rndState", rnd_state, 128'h0);
      checkOutput("rst_outData", out_data, 128'h0);
      checkOutput("rst_rndSelect", 128'(rnd_select), 128'(0));
      rst = 1'b0;
      tick();
      checkOutput("rst_inReady", 128'(in_ready), 128'(1));

      // Zero block with zero key: XOR of round numbers 1..10 gives 0xB.
      $display("[TB] zero block, out_ready high");
      applyStimulus(1'b1, '0, 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("s1_busy", 128'(busy), 128'(1));
      checkOutput("s1_inReadyLow", 128'(in_ready), 128'(0));
      for (int k = 1; k <= NR; k++) begin
         checkOutput("s1_rndNum", 128'(rnd_num), 128'(k));
         checkOutput("s1_rndFinal", 128'(rnd_final), 128'(k == NR));
         checkOutput("s1_noValid", 128'(out_valid), 128'(0));
         tick();
      end
      checkOutput("s1_outValid", 128'(out_valid), 128'(1));
      checkOutput("s1_outData", out_data, 128'hB);
      checkOutput("s1_finalInDone", 128'(rnd_final), 128'(0));
      checkOutput("s1_numHeld", 128'(rnd_num), 128'(NR));
      tick();
      checkOutput("s1_validCleared", 128'(out_valid), 128'(0));
      checkOutput("s1_idleBusy", 128'(busy), 128'(0));
      checkOutput("s1_idleReady", 128'(in_ready), 128'(1));

      // Keyed block with a five-cycle output stall and junk offered meanwhile.
      $display("[TB] keyed block with output stall");
      applyStimulus(1'b1, 128'h11223344556677889900aabbccddeeff, 1'b0,
                    128'h1d0e070381c06030984c2693492492c9, 1'b0);
      tick();
      checkOutput("s2_whitened", rnd_state, 128'h0c2c3447d4a617b8014c8c2885f97c36);
      applyStimulus(1'b1, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b1,
                    128'h1d0e070381c06030984c2693492492c9, 1'b0);
      for (int k = 1; k <= NR; k++) begin
         checkOutput("s2_runInReady", 128'(in_ready), 128'(0));
         tick();
      end
      for (int s = 0; s < 5; s++) begin
         checkOutput("s2_stallValid", 128'(out_valid), 128'(1));
         checkOutput("s2_stallData", out_data, 128'h0c2c3447d4a617b8014c8c2885f97c3d);
         checkOutput("s2_stallInReady", 128'(in_ready), 128'(0));
         checkOutput("s2_stallSelect", 128'(rnd_select), 128'(0));
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("s2_releaseData", out_data, 128'h0c2c3447d4a617b8014c8c2885f97c3d);
      tick();
      checkOutput("s2_validCleared", 128'(out_valid), 128'(0));
      checkOutput("s2_idleBusy", 128'(busy), 128'(0));

      // Reset in the middle of round 5 discards the block.
      $display("[TB] reset mid-run");
      applyStimulus(1'b1, 128'h5, 1'b1, '0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 4; k++) tick();
      checkOutput("s3_rndNumFive", 128'(rnd_num), 128'(5));
      rst = 1'b1;
      #2;
      checkOutput("s3_asyncBusy", 128'(busy), 128'(0));
      checkOutput("s3_asyncNum", 128'(rnd_num), 128'(0));
      checkOutput("s3_asyncState", rnd_state, 128'h0);
      checkOutput("s3_asyncSelect", 128'(rnd_select), 128'(0));
      checkOutput("s3_asyncValid", 128'(out_valid), 128'(0));
      tick();
      rst = 1'b0;
      tick();
      checkOutput("s3_inReadyAfter", 128'(in_ready), 128'(1));
      validSeen = 0;
      for (int k = 0; k < 15; k++) begin
         if (out_valid) validSeen++;
         tick();
      end
      checkOutput("s3_noOutput", 128'(validSeen), 128'(0));
      applyStimulus(1'b1, 128'h5, 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      for (int k = 0; k < NR; k++) tick();
      checkOutput("s3_newValid", 128'(out_valid), 128'(1));
      checkOutput("s3_newData", out_data, 128'hE);
      tick();
      checkOutput("s3_newIdle", 128'(busy), 128'(0));

      // Select latched at acceptance survives toggling of in_select.
      $display("[TB] select hold");
      applyStimulus(1'b1, '0, 1'b1, '0, 1'b0);
      tick();
      for (int k = 1; k <= NR; k++) begin
         selBit = 1'(k);
         applyStimulus(1'b0, '0, selBit, '0, 1'b0);
         checkOutput("s4_runSelect", 128'(rnd_select), 128'(1));
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      for (int s = 0; s < 2; s++) begin
         checkOutput("s4_doneValid", 128'(out_valid), 128'(1));
         checkOutput("s4_doneSelect", 128'(rnd_select), 128'(1));
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("s4_handoffSelect", 128'(rnd_select), 128'(1));
      tick();
      checkOutput("s4_idle", 128'(busy), 128'(0));

      // Two blocks offered continuously: acceptance spacing depends on overlap.
      $display("[TB] back-to-back blocks");
      applyStimulus(1'b1, '0, 1'b0, '0, 1'b1);
      accepts = 0;
      firstEdge = 0;
      secondEdge = 0;
      for (int e = 1; e <= 40 && accepts < 2; e++) begin
         if (in_ready) begin
            accepts++;
            if (accepts == 1) firstEdge = e;
            else secondEdge = e;
         end
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("s5_twoAccepts", 128'(accepts), 128'(2));
      checkOutput("s5_gap", 128'(secondEdge - firstEdge), 128'(ExpGap));
      for (int k = 0; k < NR; k++) tick();
      checkOutput("s5_secondValid", 128'(out_valid), 128'(1));
      checkOutput("s5_secondData", out_data, 128'hB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
